// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - scan sequencer driving a 4:1 mux select and capturing one bit per channel
module mux_scan_sequencer #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       w,
  input  logic       ack,
  output logic [1:0] s,
  output logic       busy,
  output logic [3:0] sample,
  output logic       valid,
  output logic       overrun
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    s_nx;
  logic          busy_nx, valid_nx, overrun_nx;
  logic [3:0]    sample_nx;
  // bits captured during the scan in progress; only published to sample in DONE
  logic [3:0]    shadow, shadow_nx;

  // state and output registers; reset discards any partial shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      s       <= 2'd0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      sample  <= 4'b0000;
      shadow  <= 4'b0000;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      s       <= s_nx;
      busy    <= busy_nx;
      valid   <= valid_nx;
      overrun <= overrun_nx;
      sample  <= sample_nx;
      shadow  <= shadow_nx;
    end
  end

  // next-state and next-output logic for the scan sequence and handshake
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    s_nx       = s;
    busy_nx    = busy;
    valid_nx   = valid;
    overrun_nx = overrun;
    sample_nx  = sample;
    shadow_nx  = shadow;

    // ack clears valid in any state; DONE below overrides with the new sample
    if (valid && ack) begin
      valid_nx = 1'b0;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = SCAN;
          s_nx       = 2'd0;
          cnt_nx     = '0;
          busy_nx    = 1'b1;
          overrun_nx = 1'b0;
        end
      end

      SCAN: begin
        if (cnt != CNT_LAST) begin
          cnt_nx = cnt + CNT_ONE;
        end else begin
          // last dwell cycle: the mux output has had DWELL-1 cycles to settle
          shadow_nx[s] = w;
          cnt_nx       = '0;
          if (s == 2'd3) begin
            state_nx = DONE;
          end else begin
            s_nx = s + 2'd1;
          end
        end
      end

      DONE: begin
        sample_nx = shadow;
        valid_nx  = 1'b1;
        // an ack on this same edge counts as consuming the old word
        if (valid && !ack) begin
          overrun_nx = 1'b1;
        end
        s_nx   = 2'd0;
        cnt_nx = '0;
        if (continuous) begin
          state_nx = SCAN;
        end else begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end
      end

      default: begin
        state_nx = IDLE;
        s_nx     = 2'd0;
        cnt_nx   = '0;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - self-checking bench for mux_scan_sequencer
module tb_mux_scan_sequencer;

  localparam int DWELL  = 4;
  localparam int SCAN_T = 4 * DWELL;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       ack = 1'b0;
  logic       w;
  logic [1:0] s;
  logic       busy;
  logic [3:0] sample;
  logic       valid;
  logic       overrun;

  logic [3:0] chan = 4'b0000;
  logic       glitch_en = 1'b0;
  logic       w_glitch = 1'b0;

  int checks = 0;
  int failures = 0;

  // model state: a timeline position within the scan instead of channel/counter registers
  bit         m_busy;
  int         m_t;
  bit         m_valid;
  bit         m_overrun;
  logic [3:0] m_sample;
  logic [3:0] m_shadow;

  mux_scan_sequencer #(.DWELL(DWELL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .continuous (continuous),
    .w          (w),
    .ack        (ack),
    .s          (s),
    .busy       (busy),
    .sample     (sample),
    .valid      (valid),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // the mux being scanned, or a settling waveform that is only correct on the last dwell cycle
  assign w = glitch_en ? w_glitch : chan[s];

  function automatic logic glitch_value(int t);
    return ((t % DWELL) == DWELL - 1) ? 1'b1 : 1'(t % 2);
  endfunction

  function automatic logic [1:0] model_s();
    int k;
    if (!m_busy) return 2'd0;
    k = m_t / DWELL;
    if (k > 3) k = 3;
    return 2'(k);
  endfunction

  // behavioural model advanced on each clock edge
  always @(posedge clk or negedge rst_n) begin
    bit   nv;
    logic ew;
    if (!rst_n) begin
      m_busy = 0; m_t = 0; m_valid = 0; m_overrun = 0;
      m_sample = 4'b0000; m_shadow = 4'b0000;
    end else begin
      nv = m_valid;
      if (m_valid && ack) nv = 0;
      if (m_busy) begin
        if (m_t == SCAN_T) begin
          m_sample = m_shadow;
          if (m_valid && !ack) m_overrun = 1;
          nv = 1;
          m_t = 0;
          if (!continuous) m_busy = 0;
        end else begin
          if ((m_t % DWELL) == DWELL - 1) begin
            ew = glitch_en ? glitch_value(m_t) : chan[m_t / DWELL];
            m_shadow[m_t / DWELL] = ew;
          end
          m_t = m_t + 1;
        end
      end else if (start) begin
        m_busy = 1;
        m_t = 0;
        m_overrun = 0;
      end
      m_valid = nv;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    chk("cyc_s",       32'(s),       32'(model_s()));
    chk("cyc_busy",    32'(busy),    32'(m_busy));
    chk("cyc_valid",   32'(valid),   32'(m_valid));
    chk("cyc_overrun", 32'(overrun), 32'(m_overrun));
    chk("cyc_sample",  32'(sample),  32'(m_sample));
    w_glitch = glitch_value(m_t);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 60; i++) begin
      if (!busy) break;
      cyc(1);
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset takes effect with no clock edge
    rst_n = 1'b0;
    #2;
    chk("rst0_s", 32'(s), 32'd0);
    chk("rst0_busy", 32'(busy), 32'd0);
    chk("rst0_valid", 32'(valid), 32'd0);
    chk("rst0_overrun", 32'(overrun), 32'd0);
    chk("rst0_sample", 32'(sample), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // single scan with a start retrigger mid-scan that must be ignored
    chan = 4'b1010;
    pulse_start();
    cyc(4);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(11);
    chk("single_valid_n17", 32'(valid), 32'd0);
    chk("single_busy_n17", 32'(busy), 32'd1);
    chk("single_s_n17", 32'(s), 32'd3);
    cyc(1);
    chk("single_valid_n18", 32'(valid), 32'd1);
    chk("single_sample", 32'(sample), 32'b1010);
    chk("single_busy_done", 32'(busy), 32'd0);
    pulse_ack();
    chk("idle_ack_valid", 32'(valid), 32'd0);

    // settling: only the last dwell cycle of each channel is captured
    glitch_en = 1'b1;
    pulse_start();
    cyc(17);
    chk("settle_sample", 32'(sample), 32'b1111);
    chk("settle_valid", 32'(valid), 32'd1);
    glitch_en = 1'b0;
    pulse_ack();

    // continuous with no ack: second completion flags overrun
    chan = 4'b0001;
    continuous = 1'b1;
    pulse_start();
    cyc(17);
    chk("cont_valid_n18", 32'(valid), 32'd1);
    chk("cont_sample", 32'(sample), 32'b0001);
    chk("cont_overrun_n18", 32'(overrun), 32'd0);
    cyc(16);
    chk("cont_overrun_n34", 32'(overrun), 32'd0);
    cyc(1);
    chk("cont_overrun_n35", 32'(overrun), 32'd1);
    chk("cont_busy_n35", 32'(busy), 32'd1);
    continuous = 1'b0;
    wait_idle("cont_to_idle");
    pulse_ack();
    chk("cont_overrun_sticky", 32'(overrun), 32'd1);

    // continuous with ack landing on the second DONE edge
    chan = 4'b0110;
    continuous = 1'b1;
    pulse_start();
    chk("ackdone_overrun_clr", 32'(overrun), 32'd0);
    cyc(33);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk("ackdone_valid", 32'(valid), 32'd1);
    chk("ackdone_overrun", 32'(overrun), 32'd0);
    chk("ackdone_sample", 32'(sample), 32'b0110);
    continuous = 1'b0;
    wait_idle("ackdone_to_idle");
    pulse_ack();
    chk("ackdone_idle_ack", 32'(valid), 32'd0);

    // reset mid-scan while s==2, then a fresh scan
    chan = 4'b1111;
    pulse_start();
    cyc(8);
    chk("midrst_s_before", 32'(s), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_s", 32'(s), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    chk("midrst_sample", 32'(sample), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    chan = 4'b0010;
    pulse_start();
    cyc(17);
    chk("fresh_sample", 32'(sample), 32'b0010);
    chk("fresh_valid", 32'(valid), 32'd1);
    chk("fresh_busy", 32'(busy), 32'd0);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
